// File: rtl/drygascon128_host_seq.sv
// Host-side command sequencer for the drygascon128 core: streams words through the
// core's 32-bit register strobes, pulses start, waits for idle and returns read words.
module drygascon128_host_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [3:0]  cmd_ds,
    input  logic [3:0]  cmd_rounds,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        err,
    output logic [31:0] core_din,
    output logic [3:0]  core_ds,
    output logic [3:0]  core_rounds,
    output logic        core_wr_i,
    output logic        core_wr_c,
    output logic        core_wr_x,
    output logic        core_start,
    output logic        core_rd_r,
    output logic        core_rd_c,
    input  logic [31:0] core_dout,
    input  logic        core_idle
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RDREQ = 3'd4;
    localparam logic [2:0] S_RDCAP = 3'd5;
    localparam logic [2:0] S_RDOUT = 3'd6;

    localparam logic [2:0] OP_LOAD_C = 3'd0;
    localparam logic [2:0] OP_LOAD_X = 3'd1;
    localparam logic [2:0] OP_ABSORB = 3'd2;
    localparam logic [2:0] OP_G      = 3'd3;
    localparam logic [2:0] OP_READ_R = 3'd4;
    localparam logic [2:0] OP_READ_C = 3'd5;

    logic [2:0] state;
    logic [2:0] op;
    logic [3:0] wcnt;
    logic [3:0] last_idx;
    logic       step;     // second cycle of START / WAIT / RDCAP
    logic       cmd_legal;

    // NOTE: every signal driven in always_comb gets a value on every path so no latch is inferred.
    always_comb begin
        last_idx  = 4'd3;
        cmd_legal = 1'b1;
        if (op == OP_LOAD_C || op == OP_READ_C)
            last_idx = 4'd9;
        if (cmd_op > OP_READ_C)
            cmd_legal = 1'b0;
        else if ((cmd_op == OP_ABSORB || cmd_op == OP_G) && cmd_rounds == 4'd0)
            cmd_legal = 1'b0;
    end

    // Gating with core_idle makes "never accept while the core is busy" hold by construction.
    assign cmd_ready = !rst && clk_en && (state == S_IDLE) && core_idle;
    assign in_ready  = !rst && clk_en && (state == S_LOAD);
    assign busy      = (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            op          <= OP_LOAD_C;
            wcnt        <= 4'd0;
            step        <= 1'b0;
            err         <= 1'b0;
            core_din    <= 32'd0;
            core_ds     <= 4'd0;
            core_rounds <= 4'd0;
            core_wr_i   <= 1'b0;
            core_wr_c   <= 1'b0;
            core_wr_x   <= 1'b0;
            core_start  <= 1'b0;
            core_rd_r   <= 1'b0;
            core_rd_c   <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= 32'd0;
        end else if (clk_en) begin
            err        <= 1'b0;
            core_wr_i  <= 1'b0;
            core_wr_c  <= 1'b0;
            core_wr_x  <= 1'b0;
            core_start <= 1'b0;
            core_rd_r  <= 1'b0;
            core_rd_c  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_legal) begin
                            op          <= cmd_op;
                            core_ds     <= cmd_ds;
                            core_rounds <= cmd_rounds;
                            wcnt        <= 4'd0;
                            step        <= 1'b0;
                            case (cmd_op)
                                OP_G:      state <= S_START;
                                OP_READ_R,
                                OP_READ_C: state <= S_RDREQ;
                                default:   state <= S_LOAD;
                            endcase
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        core_din <= in_data;
                        case (op)
                            OP_LOAD_C: core_wr_c <= 1'b1;
                            OP_LOAD_X: core_wr_x <= 1'b1;
                            default:   core_wr_i <= 1'b1;
                        endcase
                        wcnt <= wcnt + 4'd1;
                        if (wcnt == last_idx)
                            state <= (op == OP_ABSORB) ? S_START : S_IDLE;
                    end
                end
                S_START: begin
                    // The first cycle lets the last write strobe drop before start rises.
                    if (!step) begin
                        step <= 1'b1;
                    end else begin
                        core_start <= 1'b1;
                        step       <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!step)
                        step <= 1'b1;
                    else if (core_idle)
                        state <= S_IDLE;
                end
                S_RDREQ: begin
                    if (op == OP_READ_C)
                        core_rd_c <= 1'b1;
                    else
                        core_rd_r <= 1'b1;
                    step  <= 1'b0;
                    state <= S_RDCAP;
                end
                S_RDCAP: begin
                    if (!step) begin
                        step <= 1'b1;
                    end else begin
                        out_data  <= core_dout;
                        out_valid <= 1'b1;
                        out_last  <= (wcnt == last_idx);
                        step      <= 1'b0;
                        state     <= S_RDOUT;
                    end
                end
                S_RDOUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        wcnt      <= wcnt + 4'd1;
                        state     <= out_last ? S_IDLE : S_RDREQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drygascon128_host_seq.sv
// Randomized bench for drygascon128_host_seq with a stand-in core (non-cryptographic
// permutation) and a host-level model of the C/X/I/R register contents.
module tb_drygascon128_host_seq;

    logic        clk = 1'b0;
    logic        rst, clk_en;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_ds, cmd_rounds;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_data;
    logic        busy, err;
    logic [31:0] core_din;
    logic [3:0]  core_ds, core_rounds;
    logic        core_wr_i, core_wr_c, core_wr_x, core_start, core_rd_r, core_rd_c;
    logic [31:0] core_dout;
    logic        core_idle;

    drygascon128_host_seq dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ds(cmd_ds), .cmd_rounds(cmd_rounds),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err),
        .core_din(core_din), .core_ds(core_ds), .core_rounds(core_rounds),
        .core_wr_i(core_wr_i), .core_wr_c(core_wr_c), .core_wr_x(core_wr_x),
        .core_start(core_start), .core_rd_r(core_rd_r), .core_rd_c(core_rd_c),
        .core_dout(core_dout), .core_idle(core_idle)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit gap_mode = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Stand-in permutation shared by the fake core and the host model.
    function automatic logic [9:0][31:0] g_perm(input logic [9:0][31:0] c_in,
            input logic [3:0][31:0] x, input logic [3:0][31:0] i,
            input logic [3:0] ds, input logic [3:0] rounds, input bit absorb);
        logic [9:0][31:0] c;
        logic [31:0] t;
        c = c_in;
        if (absorb)
            for (int k = 0; k < 10; k++) c[k] = c[k] ^ i[k % 4] ^ (32'(ds) << (3 * k));
        for (int r = 0; r < int'(rounds); r++)
            for (int k = 0; k < 10; k++) begin
                t = (c[k] + c[(k + 1) % 10]) ^ x[(k + r) % 4] ^ 32'(r);
                c[k] = {t[26:0], t[31:27]};
            end
        return c;
    endfunction

    function automatic logic [3:0][31:0] r_of(input logic [9:0][31:0] c);
        logic [3:0][31:0] r;
        for (int j = 0; j < 4; j++) r[j] = c[j] ^ c[j + 4] ^ c[8 + (j % 2)];
        return r;
    endfunction

    // Fake core: register file with wrapping word counters, registered dout, idle after start.
    logic [9:0][31:0] mc;
    logic [3:0][31:0] mx, mi, mr;
    int cnt_c, cnt_x, cnt_i, cnt_r, cnt_rc, busy_cnt;
    bit i_full;
    int n_wr_c = 0, n_wr_x = 0, n_wr_i = 0, n_start = 0, n_rd_r = 0, n_rd_c = 0, n_err = 0;
    int conflicts = 0, inv_viol = 0, start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            cnt_c <= 0; cnt_x <= 0; cnt_i <= 0; cnt_r <= 0; cnt_rc <= 0;
            busy_cnt <= 0; i_full <= 0; core_idle <= 1'b1; core_dout <= 32'd0;
        end else if (clk_en) begin
            if (core_wr_c) begin mc[cnt_c] <= core_din; cnt_c <= (cnt_c == 9) ? 0 : cnt_c + 1; n_wr_c <= n_wr_c + 1; end
            if (core_wr_x) begin mx[cnt_x] <= core_din; cnt_x <= (cnt_x == 3) ? 0 : cnt_x + 1; n_wr_x <= n_wr_x + 1; end
            if (core_wr_i) begin
                mi[cnt_i] <= core_din;
                n_wr_i <= n_wr_i + 1;
                if (cnt_i == 3) begin cnt_i <= 0; i_full <= 1; end else cnt_i <= cnt_i + 1;
            end
            if (core_start && (core_wr_c || core_wr_x || core_wr_i)) conflicts <= conflicts + 1;
            if (core_start) begin
                mc <= g_perm(mc, mx, mi, core_ds, core_rounds, i_full);
                mr <= r_of(g_perm(mc, mx, mi, core_ds, core_rounds, i_full));
                i_full <= 0; core_idle <= 1'b0; busy_cnt <= int'(core_rounds) + 2;
                n_start <= n_start + 1; start_cyc <= cyc;
            end else if (!core_idle) begin
                if (busy_cnt == 1) core_idle <= 1'b1;
                busy_cnt <= busy_cnt - 1;
            end
            if (core_rd_r) begin core_dout <= mr[cnt_r]; cnt_r <= (cnt_r == 3) ? 0 : cnt_r + 1; n_rd_r <= n_rd_r + 1; end
            if (core_rd_c) begin core_dout <= mc[cnt_rc]; cnt_rc <= (cnt_rc == 9) ? 0 : cnt_rc + 1; n_rd_c <= n_rd_c + 1; end
            if (err) n_err <= n_err + 1;
            if (cmd_valid && cmd_ready && !core_idle) inv_viol <= inv_viol + 1;
        end
    end

    // Host-level expected register contents.
    logic [9:0][31:0] c_m;
    logic [3:0][31:0] x_m, i_m, r_m;

    task automatic tick();
        @(negedge clk);
        clk_en = gap_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [3:0] ds, input logic [3:0] rounds, output int acc);
        bit done = 0;
        bit hs;
        acc = 0;
        cmd_op = op; cmd_ds = ds; cmd_rounds = rounds; cmd_valid = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            #1 hs = cmd_ready;
            @(posedge clk);
            #1 if (hs) begin done = 1; acc = cyc; end
            tick();
        end
        cmd_valid = 1'b0;
        if (!done) check("cmd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_words(input int n, input logic [9:0][31:0] w, output int last_acc);
        bit hs;
        last_acc = 0;
        for (int j = 0; j < n; j++) begin
            bit done = 0;
            in_valid = 1'b1; in_data = w[j];
            for (int k = 0; k < 300 && !done; k++) begin
                #1 hs = in_ready;
                @(posedge clk);
                #1 if (hs) begin done = 1; last_acc = cyc; end
                tick();
            end
            if (!done) check("word_accept_timeout", 32'(j), 32'hffff_ffff);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        #1;
        while (busy && k < 500) begin tick(); #1; k++; end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
        tick(); tick();
    endtask

    task automatic read_words(input string tag, input int n, input bit stall, input logic [9:0][31:0] exp, output int first_cyc);
        int idx = 0;
        bit prev_hold = 0;
        logic [31:0] prev_data = '0;
        first_cyc = -1;
        for (int k = 0; k < 2000 && idx < n; k++) begin
            out_ready = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            #1;
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (prev_hold) check({tag, "_hold"}, out_data, prev_data);
                if (out_ready && clk_en) begin
                    check({tag, "_data"}, out_data, exp[idx]);
                    check({tag, "_last"}, 32'(out_last), 32'(idx == n - 1));
                    idx++;
                end
            end
            prev_hold = out_valid && !(out_ready && clk_en);
            prev_data = out_data;
            @(posedge clk);
            tick();
        end
        out_ready = 1'b0;
        if (idx != n) check({tag, "_count"}, 32'(idx), 32'(n));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ctrl"}, 32'({cmd_ready, in_ready, out_valid, out_last, busy, err}), 32'd0);
        check({tag, "_strobes"}, 32'({core_wr_i, core_wr_c, core_wr_x, core_start, core_rd_r, core_rd_c}), 32'd0);
        check({tag, "_din"}, core_din, 32'd0);
        check({tag, "_ds_rounds"}, 32'({core_ds, core_rounds}), 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, last, fv, s0, i0, r0, e0, st0;
        logic [9:0][31:0] w, e;
        rst = 1'b1; clk_en = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ds = '0; cmd_rounds = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        #1 check_reset_state("reset");
        rst = 1'b0;
        tick();
        #1 check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // LOAD_C 0..9 then READ_C.
        for (int k = 0; k < 10; k++) w[k] = 32'(k);
        c_m = w;
        s0 = n_wr_c;
        send_cmd(3'd0, 4'd0, 4'd0, acc);
        send_words(10, w, last);
        wait_idle();
        check("wr_c_pulses", 32'(n_wr_c - s0), 32'd10);
        send_cmd(3'd5, 4'd0, 4'd0, acc);
        read_words("read_c", 10, 1'b0, c_m, fv);
        check("read_latency", 32'(fv - acc), 32'd3);
        wait_idle();

        // Random C and X, then ABSORB ds=1 rounds=11.
        for (int k = 0; k < 10; k++) w[k] = $urandom;
        c_m = w;
        send_cmd(3'd0, 4'd0, 4'd0, acc); send_words(10, w, last); wait_idle();
        for (int k = 0; k < 10; k++) w[k] = $urandom;
        x_m = w[3:0];
        send_cmd(3'd1, 4'd0, 4'd0, acc); send_words(4, w, last); wait_idle();
        for (int k = 0; k < 10; k++) w[k] = $urandom;
        i_m = w[3:0];
        s0 = n_start;
        send_cmd(3'd2, 4'd1, 4'd11, acc);
        send_words(4, w, last);
        wait_idle();
        check("absorb_start_pulses", 32'(n_start - s0), 32'd1);
        check("absorb_start_timing", 32'(start_cyc - last), 32'd2);
        c_m = g_perm(c_m, x_m, i_m, 4'd1, 4'd11, 1'b1);
        r_m = r_of(c_m);
        e = '0; e[3:0] = r_m;
        send_cmd(3'd4, 4'd0, 4'd0, acc);
        read_words("absorb_r", 4, 1'b0, e, fv);
        wait_idle();

        // G-only call: no input words, no I writes.
        i0 = n_wr_i;
        send_cmd(3'd3, 4'($urandom_range(0, 15)), 4'd11, acc);
        wait_idle();
        check("g_wr_i_pulses", 32'(n_wr_i - i0), 32'd0);
        check("g_start_timing", 32'(start_cyc - acc), 32'd2);
        c_m = g_perm(c_m, x_m, i_m, 4'd0, 4'd11, 1'b0);
        r_m = r_of(c_m);
        e = '0; e[3:0] = r_m;
        send_cmd(3'd4, 4'd0, 4'd0, acc);
        read_words("g_r", 4, 1'b0, e, fv);
        wait_idle();

        // READ_R with a stalling consumer.
        r0 = n_rd_r;
        send_cmd(3'd4, 4'd0, 4'd0, acc);
        read_words("stall_r", 4, 1'b1, e, fv);
        wait_idle();
        check("stall_rd_r_pulses", 32'(n_rd_r - r0), 32'd4);

        // Illegal commands.
        st0 = n_wr_c + n_wr_x + n_wr_i + n_start + n_rd_r + n_rd_c;
        e0 = n_err;
        send_cmd(3'd7, 4'd0, 4'd5, acc);
        repeat (3) tick();
        check("illegal_op_err", 32'(n_err - e0), 32'd1);
        send_cmd(3'd2, 4'd3, 4'd0, acc);
        repeat (3) tick();
        #1;
        check("rounds0_err", 32'(n_err - e0), 32'd2);
        check("illegal_busy", 32'(busy), 32'd0);
        check("illegal_no_strobes", 32'(n_wr_c + n_wr_x + n_wr_i + n_start + n_rd_r + n_rd_c - st0), 32'd0);

        // Reset in the middle of LOAD_X, then a full LOAD_X with clk_en gaps.
        for (int k = 0; k < 10; k++) w[k] = $urandom;
        send_cmd(3'd1, 4'd5, 4'd7, acc);
        send_words(2, w, last);
        rst = 1'b1;
        tick();
        #1 check_reset_state("midop_reset");
        rst = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) w[k] = $urandom;
        gap_mode = 1;
        send_cmd(3'd1, 4'd0, 4'd0, acc);
        send_words(4, w, last);
        gap_mode = 0;
        wait_idle();
        for (int k = 0; k < 4; k++) check($sformatf("x_word%0d", k), mx[k], w[k]);

        check("cmd_while_core_busy", 32'(inv_viol), 32'd0);
        check("start_write_overlap", 32'(conflicts), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
